// File: rtl/mips_pkg.sv
// Shared MIPS encodings, write-back source select and load-type enums, plus the W-stage decoder.
package mips_pkg;

    localparam int XLEN = 32;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ANDI    = 6'h0c;
    localparam logic [5:0] OP_ORI     = 6'h0d;
    localparam logic [5:0] OP_LUI     = 6'h0f;
    localparam logic [5:0] OP_COP0    = 6'h10;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LH      = 6'h21;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_LHU     = 6'h25;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_MFHI = 6'h10;
    localparam logic [5:0] FN_MFLO = 6'h12;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2a;
    localparam logic [5:0] FN_SLTU = 6'h2b;

    localparam logic [4:0] RS_MF  = 5'h00;
    localparam logic [4:0] REG_RA = 5'd31;

    typedef enum logic [2:0] {WD_NONE, WD_ALU, WD_DM, WD_PC8, WD_HL, WD_CP0} wd_sel_t;
    typedef enum logic [2:0] {LD_W, LD_H, LD_HU, LD_B, LD_BU} ld_t;

    typedef struct packed {
        wd_sel_t    sel;
        logic [4:0] dst;
        ld_t        ld;
    } wb_dec_t;

    function automatic wb_dec_t decode_wb(input logic [31:0] ir);
        wb_dec_t d;
        d.sel = WD_NONE;
        d.dst = ir[15:11];
        d.ld  = LD_W;
        case (ir[31:26])
            OP_SPECIAL: begin
                case (ir[5:0])
                    FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
                    FN_SLT, FN_SLTU, FN_SLL: d.sel = WD_ALU;
                    FN_JALR:                 d.sel = WD_PC8;
                    FN_MFHI, FN_MFLO:        d.sel = WD_HL;
                    default:                 d.sel = WD_NONE;
                endcase
            end
            OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: begin
                d.sel = WD_ALU;
                d.dst = ir[20:16];
            end
            OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU: begin
                d.sel = WD_DM;
                d.dst = ir[20:16];
                case (ir[31:26])
                    OP_LH:   d.ld = LD_H;
                    OP_LHU:  d.ld = LD_HU;
                    OP_LB:   d.ld = LD_B;
                    OP_LBU:  d.ld = LD_BU;
                    default: d.ld = LD_W;
                endcase
            end
            OP_JAL: begin
                d.sel = WD_PC8;
                d.dst = REG_RA;
            end
            OP_COP0: begin
                // Only mfc0 writes the GRF; mtc0/eret share the opcode.
                if (ir[25:21] == RS_MF) begin
                    d.sel = WD_CP0;
                    d.dst = ir[20:16];
                end
            end
            default: d.sel = WD_NONE;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/wb_dm_ext.sv
// Load data extractor: selects byte/half/word from an aligned DM word and sign/zero extends it.
module wb_dm_ext
    import mips_pkg::*;
(
    input  logic [XLEN-1:0] word,
    input  logic [1:0]      addr,
    input  ld_t             ld,
    output logic [XLEN-1:0] ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[8*addr +: 8];
        // Halves are selected by addr[1] only; misalignment is trapped upstream.
        half_sel = addr[1] ? word[31:16] : word[15:0];
        case (ld)
            LD_B:    ext = {{24{byte_sel[7]}}, byte_sel};
            LD_BU:   ext = {24'h0, byte_sel};
            LD_H:    ext = {{16{half_sel[15]}}, half_sel};
            LD_HU:   ext = {16'h0, half_sel};
            default: ext = word;
        endcase
    end

endmodule

// File: rtl/wb_grf.sv
// MIPS W stage and 32x32 general register file with write-through read bypass.
// Optional macro GRF_TRACE_EN adds a simulation-only write trace.
module wb_grf
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] W_PC,
    input  logic [DATA_W-1:0] W_IR,
    input  logic [DATA_W-1:0] W_DMRD,
    input  logic [DATA_W-1:0] W_ALUO,
    input  logic [DATA_W-1:0] W_PC8,
    input  logic [DATA_W-1:0] W_HL,
    input  logic [DATA_W-1:0] W_CP0,
    input  logic [ADDR_W-1:0] A1,
    input  logic [ADDR_W-1:0] A2,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    output logic              W_WE,
    output logic [ADDR_W-1:0] W_A3,
    output logic [DATA_W-1:0] W_WD
);

    localparam int NREGS = 2 ** ADDR_W;

    wb_dec_t           dec;
    logic [DATA_W-1:0] dm_ext;
    logic [DATA_W-1:0] wd_raw;
    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];

    logic unused_pc;
    assign unused_pc = ^W_PC;

    assign dec = decode_wb(W_IR);

    wb_dm_ext u_dm_ext (
        .word (W_DMRD),
        .addr (W_ALUO[1:0]),
        .ld   (dec.ld),
        .ext  (dm_ext)
    );

    always_comb begin
        case (dec.sel)
            WD_ALU:  wd_raw = W_ALUO;
            WD_DM:   wd_raw = dm_ext;
            WD_PC8:  wd_raw = W_PC8;
            WD_HL:   wd_raw = W_HL;
            WD_CP0:  wd_raw = W_CP0;
            default: wd_raw = '0;
        endcase
    end

    // Writes to $0 are squashed here so forwarding never sees them.
    always_comb begin
        W_WE = (dec.sel != WD_NONE) && (dec.dst != '0);
        W_A3 = W_WE ? dec.dst : '0;
        W_WD = W_WE ? wd_raw : '0;
    end

    always_comb begin
        regs_d = regs_q;
        if (W_WE) begin
            regs_d[W_A3] = W_WD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        if (A1 == '0)                    RD1 = '0;
        else if (W_WE && (A1 == W_A3))   RD1 = W_WD;
        else                             RD1 = regs_q[A1];
        if (A2 == '0)                    RD2 = '0;
        else if (W_WE && (A2 == W_A3))   RD2 = W_WD;
        else                             RD2 = regs_q[A2];
    end

`ifdef GRF_TRACE_EN
    always @(posedge clk) begin
        if (!rst && W_WE) begin
            $display("%0t@%08h: $%2d <= %08h", $time, W_PC, W_A3, W_WD);
        end
    end
`endif

endmodule

// File: tb/tb_wb_grf.sv
// Directed-vector bench for wb_grf with a queue scoreboard checked by an independent monitor.
module tb_wb_grf;

    localparam logic [5:0] T_LB = 6'h20, T_LH = 6'h21, T_LW = 6'h23, T_LBU = 6'h24, T_LHU = 6'h25;
    localparam logic [5:0] T_ORI = 6'h0d, T_LUI = 6'h0f, T_SW = 6'h2b, T_BEQ = 6'h04;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] W_PC, W_IR, W_DMRD, W_ALUO, W_PC8, W_HL, W_CP0;
    logic [4:0]  A1, A2;
    logic [31:0] RD1, RD2, W_WD;
    logic        W_WE;
    logic [4:0]  W_A3;

    always #5 clk = ~clk;

    wb_grf dut (
        .clk(clk), .rst(rst), .W_PC(W_PC), .W_IR(W_IR), .W_DMRD(W_DMRD),
        .W_ALUO(W_ALUO), .W_PC8(W_PC8), .W_HL(W_HL), .W_CP0(W_CP0),
        .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2),
        .W_WE(W_WE), .W_A3(W_A3), .W_WD(W_WD)
    );

    typedef struct {
        string       name;
        logic        we;
        logic [4:0]  a3;
        logic [31:0] wd;
        logic [31:0] rd1;
        logic [31:0] rd2;
    } exp_t;

    exp_t sbq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic logic [31:0] rt_(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    function automatic logic [31:0] it_(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic set_defaults();
        rst    = 1'b0;
        W_PC   = 32'h0000_3000;
        W_IR   = 32'h0;
        W_DMRD = 32'hD0D0_D0D0;
        W_ALUO = 32'hA1A1_A1A0;
        W_PC8  = 32'h0000_8888;
        W_HL   = 32'h4848_4848;
        W_CP0  = 32'hC0C0_C0C0;
        A1     = 5'd0;
        A2     = 5'd0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        set_defaults();
    endtask

    task automatic expect_(input string nm, input logic we, input logic [4:0] a3,
                           input logic [31:0] wd, input logic [31:0] rd1, input logic [31:0] rd2);
        exp_t e;
        e.name = nm; e.we = we; e.a3 = a3; e.wd = wd; e.rd1 = rd1; e.rd2 = rd2;
        sbq.push_back(e);
    endtask

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %08h expected %08h", nm, fld, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            chk(e.name, "W_WE", {31'h0, W_WE}, {31'h0, e.we});
            chk(e.name, "W_A3", {27'h0, W_A3}, {27'h0, e.a3});
            chk(e.name, "W_WD", W_WD, e.wd);
            chk(e.name, "RD1", RD1, e.rd1);
            chk(e.name, "RD2", RD2, e.rd2);
        end
    end

    initial begin
        set_defaults();
        rst = 1'b1;
        repeat (3) @(posedge clk);

        // Preload every register; port 2 reads back the previous write from storage.
        for (int r = 1; r < 32; r++) begin
            cyc();
            W_IR = rt_(5'd1, 5'd2, 5'(r), 6'h21); W_ALUO = 32'h1000 + r;
            A1 = 5'(r); A2 = 5'(r - 1);
            expect_("preload", 1'b1, 5'(r), 32'h1000 + r, 32'h1000 + r,
                    (r == 1) ? 32'h0 : 32'h1000 + r - 1);
        end

        // Write to $4 in the reset cycle: combinational outputs still show it, storage must not.
        cyc(); rst = 1'b1; W_IR = rt_(5'd1, 5'd2, 5'd4, 6'h21); W_ALUO = 32'h4444; A1 = 5'd4; A2 = 5'd5;
        expect_("rst_write", 1'b1, 5'd4, 32'h4444, 32'h4444, 32'h1005);
        for (int r = 1; r < 32; r++) begin
            cyc(); A1 = 5'(r); A2 = 5'(32 - r);
            expect_("post_reset", 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
        end

        cyc(); W_IR = rt_(5'd1, 5'd2, 5'd3, 6'h21); W_ALUO = 32'h1234; A1 = 5'd3;
        expect_("addu_bypass", 1'b1, 5'd3, 32'h1234, 32'h1234, 32'h0);
        cyc(); A1 = 5'd3; A2 = 5'd3;
        expect_("addu_stored", 1'b0, 5'd0, 32'h0, 32'h1234, 32'h1234);

        cyc(); W_IR = it_(T_LB, 5'd0, 5'd5, 16'h2002); W_DMRD = 32'h80FF_7F01; W_ALUO = 32'h2002; A1 = 5'd5; A2 = 5'd3;
        expect_("lb_k2", 1'b1, 5'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234);
        cyc(); W_IR = it_(T_LBU, 5'd0, 5'd6, 16'h2003); W_DMRD = 32'h80FF_7F01; W_ALUO = 32'h2003; A1 = 5'd5; A2 = 5'd6;
        expect_("lbu_k3", 1'b1, 5'd6, 32'h80, 32'hFFFF_FFFF, 32'h80);
        cyc(); W_IR = it_(T_LH, 5'd0, 5'd8, 16'h2002); W_DMRD = 32'h80FF_7F01; W_ALUO = 32'h2002; A1 = 5'd8; A2 = 5'd6;
        expect_("lh_hi", 1'b1, 5'd8, 32'hFFFF_80FF, 32'hFFFF_80FF, 32'h80);
        cyc(); W_IR = it_(T_LHU, 5'd0, 5'd10, 16'h2001); W_DMRD = 32'h80FF_7F01; W_ALUO = 32'h2001; A1 = 5'd8; A2 = 5'd10;
        expect_("lhu_lo_odd", 1'b1, 5'd10, 32'h7F01, 32'hFFFF_80FF, 32'h7F01);
        cyc(); W_IR = it_(T_LW, 5'd0, 5'd11, 16'h2000); W_DMRD = 32'h80FF_7F01; W_ALUO = 32'h2000; A1 = 5'd11;
        expect_("lw", 1'b1, 5'd11, 32'h80FF_7F01, 32'h80FF_7F01, 32'h0);
        cyc(); W_IR = it_(T_LB, 5'd0, 5'd17, 16'h2000); W_DMRD = 32'h80FF_7F01; W_ALUO = 32'h2000; A1 = 5'd17;
        expect_("lb_k0", 1'b1, 5'd17, 32'h01, 32'h01, 32'h0);
        cyc(); W_IR = it_(T_LBU, 5'd0, 5'd18, 16'h2001); W_DMRD = 32'h80FF_7F01; W_ALUO = 32'h2001; A2 = 5'd18;
        expect_("lbu_k1", 1'b1, 5'd18, 32'h7F, 32'h0, 32'h7F);
        cyc(); W_IR = it_(T_LH, 5'd0, 5'd19, 16'h2000); W_DMRD = 32'h80FF_7F01; W_ALUO = 32'h2000; A1 = 5'd19;
        expect_("lh_lo", 1'b1, 5'd19, 32'h7F01, 32'h7F01, 32'h0);
        cyc(); W_IR = it_(T_LHU, 5'd0, 5'd20, 16'h2003); W_DMRD = 32'h80FF_7F01; W_ALUO = 32'h2003; A1 = 5'd20;
        expect_("lhu_hi", 1'b1, 5'd20, 32'h80FF, 32'h80FF, 32'h0);
        cyc(); W_IR = it_(T_LB, 5'd0, 5'd21, 16'h2003); W_DMRD = 32'h80FF_7F01; W_ALUO = 32'h2003; A1 = 5'd21;
        expect_("lb_k3", 1'b1, 5'd21, 32'hFFFF_FF80, 32'hFFFF_FF80, 32'h0);

        cyc(); W_IR = {6'h03, 26'h40}; W_PC8 = 32'h3008; A1 = 5'd31; A2 = 5'd31;
        expect_("jal_dual_bypass", 1'b1, 5'd31, 32'h3008, 32'h3008, 32'h3008);
        cyc(); W_IR = rt_(5'd31, 5'd0, 5'd12, 6'h09); W_PC8 = 32'h4008; W_ALUO = 32'hBAD; A1 = 5'd12; A2 = 5'd31;
        expect_("jalr", 1'b1, 5'd12, 32'h4008, 32'h4008, 32'h3008);
        cyc(); W_IR = {6'h10, 5'h0, 5'd7, 5'd12, 11'h0}; W_CP0 = 32'hDEAD_BEEF; A1 = 5'd7; A2 = 5'd12;
        expect_("mfc0", 1'b1, 5'd7, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h4008);
        cyc(); W_IR = {6'h10, 5'h4, 5'd7, 5'd12, 11'h0}; W_CP0 = 32'h1111; A1 = 5'd7;
        expect_("mtc0_nowrite", 1'b0, 5'd0, 32'h0, 32'hDEAD_BEEF, 32'h0);
        cyc(); W_IR = rt_(5'd0, 5'd0, 5'd9, 6'h10); W_HL = 32'h55; A1 = 5'd9; A2 = 5'd7;
        expect_("mfhi", 1'b1, 5'd9, 32'h55, 32'h55, 32'hDEAD_BEEF);
        cyc(); W_IR = rt_(5'd0, 5'd0, 5'd13, 6'h12); W_HL = 32'h66; A1 = 5'd13; A2 = 5'd9;
        expect_("mflo", 1'b1, 5'd13, 32'h66, 32'h66, 32'h55);

        cyc(); W_IR = it_(T_ORI, 5'd0, 5'd0, 16'hFFFF); W_ALUO = 32'hFFFF;
        expect_("ori_r0", 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
        cyc(); W_IR = it_(T_ORI, 5'd0, 5'd14, 16'hFFFF); W_ALUO = 32'hFFFF; A1 = 5'd14;
        expect_("ori", 1'b1, 5'd14, 32'hFFFF, 32'hFFFF, 32'h0);
        cyc(); W_IR = it_(T_LUI, 5'd0, 5'd15, 16'hABCD); W_ALUO = 32'hABCD_0000; A1 = 5'd15; A2 = 5'd14;
        expect_("lui", 1'b1, 5'd15, 32'hABCD_0000, 32'hABCD_0000, 32'hFFFF);
        cyc(); W_IR = rt_(5'd1, 5'd2, 5'd22, 6'h2a); W_ALUO = 32'h1; A1 = 5'd22;
        expect_("slt", 1'b1, 5'd22, 32'h1, 32'h1, 32'h0);
        cyc(); W_IR = rt_(5'd0, 5'd2, 5'd23, 6'h00); W_ALUO = 32'h40; A2 = 5'd23;
        expect_("sll", 1'b1, 5'd23, 32'h40, 32'h0, 32'h40);

        cyc(); W_IR = it_(T_SW, 5'd0, 5'd3, 16'h10); W_ALUO = 32'h10; A1 = 5'd3; A2 = 5'd15;
        expect_("sw_nowrite", 1'b0, 5'd0, 32'h0, 32'h1234, 32'hABCD_0000);
        cyc(); W_IR = it_(T_BEQ, 5'd1, 5'd3, 16'h4); A1 = 5'd3; A2 = 5'd5;
        expect_("beq_nowrite", 1'b0, 5'd0, 32'h0, 32'h1234, 32'hFFFF_FFFF);
        cyc(); W_IR = rt_(5'd3, 5'd5, 5'd3, 6'h18); A1 = 5'd3;
        expect_("mult_nowrite", 1'b0, 5'd0, 32'h0, 32'h1234, 32'h0);
        cyc(); W_IR = rt_(5'd1, 5'd2, 5'd5, 6'h3F); A1 = 5'd5;
        expect_("unknown_fn", 1'b0, 5'd0, 32'h0, 32'hFFFF_FFFF, 32'h0);
        cyc(); A1 = 5'd5; A2 = 5'd6;
        expect_("nop", 1'b0, 5'd0, 32'h0, 32'hFFFF_FFFF, 32'h80);

        cyc(); A1 = 5'd11; A2 = 5'd21;
        expect_("stored_a", 1'b0, 5'd0, 32'h0, 32'h80FF_7F01, 32'hFFFF_FF80);
        cyc(); A1 = 5'd17; A2 = 5'd18;
        expect_("stored_b", 1'b0, 5'd0, 32'h0, 32'h01, 32'h7F);
        cyc(); A1 = 5'd19; A2 = 5'd20;
        expect_("stored_c", 1'b0, 5'd0, 32'h0, 32'h7F01, 32'h80FF);
        cyc(); A1 = 5'd10; A2 = 5'd13;
        expect_("stored_d", 1'b0, 5'd0, 32'h0, 32'h7F01, 32'h66);
        cyc(); A1 = 5'd12; A2 = 5'd14;
        expect_("stored_e", 1'b0, 5'd0, 32'h0, 32'h4008, 32'hFFFF);

        for (int i = 0; i < 10 && sbq.size() != 0; i++) @(negedge clk);
        #1;
        if (sbq.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
